// File: rtl/udc_host_port_if.sv
// Requester-side command/response channel of the UDC host-bus master port.
interface udc_host_port_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_start;
    logic       req_wr;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;

    modport master (
        output req_valid, req_start, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_start, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/udc_host_port.sv
// Bus master for the UDC host bus: sequences ncs/strobe timing through
// SETUP/STROBE/HOLD phases, issues start pulses and returns read data.
module udc_host_port #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic               clk,
    input  logic               reset,
    udc_host_port_if.slave     req,
    output logic               busy,
    output logic               ncs,
    output logic               nwr,
    output logic               nrd,
    output logic               A0,
    output logic               A1,
    output logic               start_in,
    inout  wire  [7:0]         din
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        START  = 3'd4
    } state_t;

    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       wr_q;
    logic [1:0] addr_q;
    logic [7:0] wdata_q;
    logic       accept;
    logic       rd_capture;
    logic       rd_done;
    logic       drive_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Strobes and ncs decode straight from state so an async reset drops them instantly.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        accept        = 1'b0;
        rd_capture    = 1'b0;
        rd_done       = 1'b0;
        drive_en      = 1'b0;
        ncs           = 1'b1;
        nwr           = 1'b1;
        nrd           = 1'b1;
        start_in      = 1'b0;
        req.req_ready = 1'b0;
        case (state)
            IDLE: begin
                req.req_ready = 1'b1;
                if (req.req_valid) begin
                    accept = 1'b1;
                    if (req.req_start) begin
                        state_nxt = START;
                    end else begin
                        state_nxt = SETUP;
                        cnt_nxt   = SETUP_LD;
                    end
                end
            end
            START: begin
                start_in  = 1'b1;
                state_nxt = IDLE;
            end
            SETUP: begin
                ncs      = 1'b0;
                drive_en = wr_q;
                if (cnt == 8'd0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = STROBE_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            STROBE: begin
                ncs      = 1'b0;
                nwr      = ~wr_q;
                nrd      = wr_q;
                drive_en = wr_q;
                if (cnt == 8'd0) begin
                    rd_capture = ~wr_q;
                    state_nxt  = HOLD;
                    cnt_nxt    = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            HOLD: begin
                ncs      = 1'b0;
                drive_en = wr_q;
                if (cnt == 8'd0) begin
                    rd_done   = ~wr_q;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address/direction only move when a bus transaction (not a start) is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q          <= 1'b0;
            addr_q        <= 2'b00;
            req.rsp_valid <= 1'b0;
            req.rsp_rdata <= 8'h00;
        end else begin
            req.rsp_valid <= rd_done;
            if (accept && !req.req_start) begin
                wr_q   <= req.req_wr;
                addr_q <= req.req_addr;
            end
            if (rd_capture) begin
                req.rsp_rdata <= din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !req.req_start && req.req_wr) begin
            wdata_q <= req.req_wdata;
        end
    end

    assign busy = (state != IDLE);
    assign A0   = addr_q[0];
    assign A1   = addr_q[1];
    assign din  = drive_en ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_udc_host_port.sv
// Directed bench for udc_host_port: vector table of single commands plus
// back-to-back, reset-abort and non-default timing sequences.
module tb_udc_host_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    udc_host_port_if rif0();
    udc_host_port_if rif1();

    wire  [7:0] din0;
    wire  [7:0] din1;
    logic busy0, ncs0, nwr0, nrd0, a0_0, a1_0, st0;
    logic busy1, ncs1, nwr1, nrd1, a0_1, a1_1, st1;
    logic park0, park1;
    logic [7:0] rdv0;

    // UDC model: drives read data while nrd is low, a parking pattern when asked.
    assign din0 = !nrd0 ? rdv0 : (park0 ? 8'h96 : 8'hzz);
    assign din1 = park1 ? 8'h96 : 8'hzz;

    udc_host_port dut0 (
        .clk(clk), .reset(reset), .req(rif0), .busy(busy0),
        .ncs(ncs0), .nwr(nwr0), .nrd(nrd0), .A0(a0_0), .A1(a1_0),
        .start_in(st0), .din(din0)
    );

    udc_host_port #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) dut1 (
        .clk(clk), .reset(reset), .req(rif1), .busy(busy1),
        .ncs(ncs1), .nwr(nwr1), .nrd(nrd1), .A0(a0_1), .A1(a1_1),
        .start_in(st1), .din(din1)
    );

    typedef struct {
        logic       start;
        logic       wr;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdval;
        logic [5:0] m_ncs;
        logic [5:0] m_nwr;
        logic [5:0] m_nrd;
        logic [5:0] m_st;
        logic [5:0] m_rsp;
        logic [5:0] m_rdy;
        logic [1:0] e_addr;
        logic [7:0] e_rdata;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Entered and left at 1 time unit after a posedge with dut0 idle.
    task automatic apply(input vec_t v, input int id);
        logic [5:0] o_ncs, o_nwr, o_nrd, o_st, o_rsp, o_rdy;
        logic [1:0] o_addr;
        logic [7:0] o_rdata, exp_din;
        int derr;
        derr = 0;
        o_addr = 2'b00;
        o_rdata = 8'h00;
        rdv0  = v.rdval;
        park0 = v.start || !v.wr;
        rif0.req_start = v.start;
        rif0.req_wr    = v.wr;
        rif0.req_addr  = v.addr;
        rif0.req_wdata = v.wdata;
        rif0.req_valid = 1'b1;
        @(posedge clk); #1;
        rif0.req_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            park0 = v.start || !v.wr || (k >= 4);
            #1;
            o_ncs[k] = !ncs0;
            o_nwr[k] = !nwr0;
            o_nrd[k] = !nrd0;
            o_st[k]  = st0;
            o_rsp[k] = rif0.rsp_valid;
            o_rdy[k] = rif0.req_ready;
            if (v.wr && !v.start && k < 4) exp_din = v.wdata;
            else if (!nrd0)                exp_din = v.rdval;
            else                           exp_din = 8'h96;
            if (din0 !== exp_din) derr++;
            if (k == 5) begin
                o_addr  = {a1_0, a0_0};
                o_rdata = rif0.rsp_rdata;
            end
            @(posedge clk); #1;
        end
        check($sformatf("v%0d ncs_low", id), 32'(o_ncs), 32'(v.m_ncs));
        check($sformatf("v%0d nwr_low", id), 32'(o_nwr), 32'(v.m_nwr));
        check($sformatf("v%0d nrd_low", id), 32'(o_nrd), 32'(v.m_nrd));
        check($sformatf("v%0d start_in", id), 32'(o_st), 32'(v.m_st));
        check($sformatf("v%0d rsp_valid", id), 32'(o_rsp), 32'(v.m_rsp));
        check($sformatf("v%0d req_ready", id), 32'(o_rdy), 32'(v.m_rdy));
        check($sformatf("v%0d addr", id), 32'(o_addr), 32'(v.e_addr));
        check($sformatf("v%0d rsp_rdata", id), 32'(o_rdata), 32'(v.e_rdata));
        check($sformatf("v%0d din_errors", id), 32'(derr), 32'd0);
    endtask

    vec_t vt [6];
    vec_t cmds [3];
    vec_t post;

    initial begin
        int acc [3];
        int idx, viol, rsp_c, rsp_cnt, dok, rel;
        logic [7:0] rsp_d;
        logic ncs_gap;
        logic [7:0] p_ncs, p_nwr, p_nrd;

        //                start wr  addr   wdata  rdval  ncs        nwr        nrd        st         rsp        rdy        addr   rdata
        vt[0] = '{1'b0, 1'b1, 2'b01, 8'hA5, 8'h00, 6'b001111, 6'b000110, 6'b000000, 6'b000000, 6'b000000, 6'b110000, 2'b01, 8'h00};
        vt[1] = '{1'b0, 1'b0, 2'b10, 8'h00, 8'h3C, 6'b001111, 6'b000000, 6'b000110, 6'b000000, 6'b010000, 6'b110000, 2'b10, 8'h3C};
        vt[2] = '{1'b1, 1'b1, 2'b11, 8'hEE, 8'h00, 6'b000000, 6'b000000, 6'b000000, 6'b000001, 6'b000000, 6'b111110, 2'b10, 8'h3C};
        vt[3] = '{1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 6'b001111, 6'b000110, 6'b000000, 6'b000000, 6'b000000, 6'b110000, 2'b11, 8'h3C};
        vt[4] = '{1'b0, 1'b0, 2'b00, 8'h00, 8'hFF, 6'b001111, 6'b000000, 6'b000110, 6'b000000, 6'b010000, 6'b110000, 2'b00, 8'hFF};
        vt[5] = '{1'b0, 1'b1, 2'b10, 8'h5A, 8'h00, 6'b001111, 6'b000110, 6'b000000, 6'b000000, 6'b000000, 6'b110000, 2'b10, 8'hFF};
        cmds[0] = '{1'b0, 1'b1, 2'b01, 8'h11, 8'h00, '0, '0, '0, '0, '0, '0, 2'b00, 8'h00};
        cmds[1] = '{1'b0, 1'b0, 2'b10, 8'h00, 8'h77, '0, '0, '0, '0, '0, '0, 2'b00, 8'h00};
        cmds[2] = '{1'b0, 1'b1, 2'b00, 8'h22, 8'h00, '0, '0, '0, '0, '0, '0, 2'b00, 8'h00};
        post    = '{1'b0, 1'b0, 2'b01, 8'h00, 8'h99, 6'b001111, 6'b000000, 6'b000110, 6'b000000, 6'b010000, 6'b110000, 2'b01, 8'h99};

        reset = 1'b1;
        park0 = 1'b0; park1 = 1'b0; rdv0 = 8'h00;
        rif0.req_valid = 1'b0; rif0.req_start = 1'b0; rif0.req_wr = 1'b0;
        rif0.req_addr = 2'b00; rif0.req_wdata = 8'h00;
        rif1.req_valid = 1'b0; rif1.req_start = 1'b0; rif1.req_wr = 1'b0;
        rif1.req_addr = 2'b00; rif1.req_wdata = 8'h00;
        #2 reset = 1'b0;
        #1;
        check("rst ncs", 32'(ncs0), 32'd1);
        check("rst nwr", 32'(nwr0), 32'd1);
        check("rst nrd", 32'(nrd0), 32'd1);
        check("rst start_in", 32'(st0), 32'd0);
        check("rst addr", 32'({a1_0, a0_0}), 32'd0);
        check("rst rsp_valid", 32'(rif0.rsp_valid), 32'd0);
        check("rst rsp_rdata", 32'(rif0.rsp_rdata), 32'd0);
        check("rst busy", 32'(busy0), 32'd0);
        check("rst req_ready", 32'(rif0.req_ready), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) apply(vt[i], i);

        // Back-to-back: valid held high across write, read, write.
        park0 = 1'b0;
        rdv0  = 8'h77;
        idx = 0; viol = 0; rsp_c = -100; rsp_d = 8'h00; ncs_gap = 1'b0;
        for (int i = 0; i < 3; i++) acc[i] = -100;
        for (int c = 0; c < 20; c++) begin
            if (idx < 3) begin
                rif0.req_start = cmds[idx].start;
                rif0.req_wr    = cmds[idx].wr;
                rif0.req_addr  = cmds[idx].addr;
                rif0.req_wdata = cmds[idx].wdata;
                rif0.req_valid = 1'b1;
            end else begin
                rif0.req_valid = 1'b0;
            end
            #1;
            if (!nwr0 && !nrd0) viol++;
            if ((!nwr0 || !nrd0) && ncs0) viol++;
            if (st0 && !ncs0) viol++;
            if (rif0.rsp_valid) begin
                rsp_c = c;
                rsp_d = rif0.rsp_rdata;
            end
            if (rif0.req_valid && rif0.req_ready) begin
                acc[idx] = c;
                if (idx == 1) ncs_gap = ncs0;
                idx++;
            end
            @(posedge clk); #1;
        end
        rif0.req_valid = 1'b0;
        check("b2b accepted", 32'(idx), 32'd3);
        check("b2b gap01", 32'(acc[1] - acc[0]), 32'd5);
        check("b2b gap12", 32'(acc[2] - acc[1]), 32'd5);
        check("b2b ncs idle", 32'(ncs_gap), 32'd1);
        check("b2b rsp cycle", 32'(rsp_c - acc[1]), 32'd5);
        check("b2b rsp data", 32'(rsp_d), 32'h77);
        check("b2b violations", 32'(viol), 32'd0);

        // Reset during the first STROBE cycle of a read.
        rdv0 = 8'h99;
        rif0.req_start = 1'b0; rif0.req_wr = 1'b0; rif0.req_addr = 2'b01;
        rif0.req_valid = 1'b1;
        @(posedge clk); #1;
        rif0.req_valid = 1'b0;
        @(posedge clk); #1;
        check("abort pre nrd", 32'(nrd0), 32'd0);
        reset = 1'b0;
        #1;
        check("abort nrd", 32'(nrd0), 32'd1);
        check("abort ncs", 32'(ncs0), 32'd1);
        check("abort busy", 32'(busy0), 32'd0);
        check("abort rsp_rdata", 32'(rif0.rsp_rdata), 32'd0);
        check("abort req_ready", 32'(rif0.req_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        rsp_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (rif0.rsp_valid) rsp_cnt++;
            @(posedge clk); #1;
        end
        check("abort no rsp", 32'(rsp_cnt), 32'd0);
        apply(post, 6);

        // Non-default timing instance: SETUP=3, STROBE=1, HOLD=2.
        rif1.req_wr = 1'b1; rif1.req_addr = 2'b10; rif1.req_wdata = 8'hC3;
        rif1.req_valid = 1'b1;
        @(posedge clk); #1;
        rif1.req_valid = 1'b0;
        dok = 0; rel = 0;
        for (int k = 0; k < 8; k++) begin
            park1 = (k >= 6);
            #1;
            p_ncs[k] = !ncs1;
            p_nwr[k] = !nwr1;
            p_nrd[k] = !nrd1;
            if (k < 6 && din1 === 8'hC3) dok++;
            if (k >= 6 && din1 === 8'h96) rel++;
            @(posedge clk); #1;
        end
        check("p ncs_low", 32'(p_ncs), 32'h3F);
        check("p nwr_low", 32'(p_nwr), 32'h08);
        check("p nrd_low", 32'(p_nrd), 32'h00);
        check("p din held", 32'(dok), 32'd6);
        check("p din released", 32'(rel), 32'd2);
        check("p addr", 32'({a1_1, a0_1}), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udc_host_port.md
# udc_host_port

Bus-master port that drives the UDC counter's host bus (ncs/nwr/nrd/A0/A1/din/start_in). It accepts register read/write and start commands from a local requester over a valid/ready handshake. It sequences chip-select and strobe timing with programmable setup, strobe and hold phases, and returns read data. It sits between the test/system controller and the UDC peripheral, as the initiator end of that peripheral's bus.

## Interface
- SETUP_CYC, 1, cycles ncs low with address/data valid before the strobe falls (≥1)
- STROBE_CYC, 2, cycles nwr/nrd held low (≥1)
- HOLD_CYC, 1, cycles ncs/address/data held after the strobe rises (≥1)
- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  command present
- req_ready  out  1  port can accept a command
- req_start  in  1  1 = start command (pulse start_in); overrides req_wr/req_addr
- req_wr  in  1  1 = register write, 0 = register read
- req_addr  in  2  register address; bit0→A0, bit1→A1
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse: read data valid
- rsp_rdata  out  8  last read data, held until the next read completes
- busy  out  1  transaction in progress (state ≠ IDLE)
- ncs, nwr, nrd  out  1 each  active-low chip select, write strobe, read strobe
- A0, A1  out  1 each  register address to UDC
- start_in  out  1  start pulse to UDC
- din  inout  8  shared data bus; driven only during write transactions, else high-Z

## Operation
- States: IDLE, SETUP, STROBE, HOLD, START.
- IDLE: req_ready=1. A handshake (req_valid & req_ready at posedge) latches the command:
  - req_start=1 → START.
  - Otherwise → SETUP.
- START: start_in=1 for exactly 1 cycle; ncs stays 1; → IDLE.
- SETUP: ncs=0, A1:A0 = latched addr, both strobes 1. For writes, din = latched wdata. Lasts SETUP_CYC cycles → STROBE.
- STROBE: ncs=0; nwr=0 (write) or nrd=0 (read). Lasts STROBE_CYC cycles. For reads, din is sampled into rsp_rdata at the posedge that ends the last STROBE cycle → HOLD.
- HOLD: ncs=0, strobes 1, address and write data held. Lasts HOLD_CYC cycles → IDLE. Completing a read sets rsp_valid=1 for the first IDLE cycle.
- Phase counter is 8 bits, loaded with (N−1) on phase entry, counts down, and advances at 0.
- din tri-state: enable = write transaction & state ∈ {SETUP, STROBE, HOLD}. It is never driven in IDLE, START, or any read phase.
- Address and data outputs change only on entering SETUP. In IDLE they keep their last values.
- req_* inputs are ignored outside IDLE. Handshake gaps leave the port idle indefinitely.

## Timing
- Reset values (immediate, asynchronous): state=IDLE, ncs=nwr=nrd=1, start_in=0, A0=A1=0, din high-Z, rsp_valid=0, rsp_rdata=0, busy=0, req_ready=1.
- Reset mid-transaction aborts at once:
  - Strobes and ncs go to 1 and din is released in the same instant.
  - No rsp_valid is issued for the aborted read.
- Write/read occupancy = SETUP_CYC+STROBE_CYC+HOLD_CYC cycles after acceptance; defaults give 4.
- Read rsp_valid appears SETUP+STROBE+HOLD cycles after the accepting edge; defaults give the 4th edge after acceptance.
- At least one IDLE cycle with ncs=1 separates consecutive transactions. With defaults, back-to-back accepts are 5 cycles apart.
- Strobes never overlap. nwr and nrd are never low in the same cycle. A strobe is never low while ncs=1.
- start_in never overlaps ncs=0.

## Test plan
- Write with defaults: req_wr=1, addr=2'b01, wdata=8'hA5 → ncs low 4 cycles, nwr low in cycles 2–3, A0=1/A1=0, din=8'hA5 throughout, then din=Z and ncs=1.
- Read with defaults: addr=2'b10, UDC model drives 8'h3C while nrd=0 → rsp_rdata=8'h3C with a one-cycle rsp_valid 4 cycles after acceptance. din is never driven by the port.
- Start command: req_start=1 → start_in high exactly one cycle, ncs/nwr/nrd stay 1, req_ready back to 1 the next cycle.
- Back-to-back: req_valid held high with write, read, write queued → accepts every 5 cycles, ncs=1 for one cycle between transactions, and read data is returned correctly.
- Reset during STROBE of a read: assert reset low mid-pulse → nrd=ncs=1 immediately, no rsp_valid, rsp_rdata=0, and the port accepts a new command after release.
- Parameter sweep: SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=2 write → ncs low 6 cycles, nwr low only in cycle 4, data stable across all 6 cycles.
